shift_exec_unit: RTL and testbench

- Multi-cycle shift execute stage directly downstream of the register file.
- Consumes read_data1 (value) and read_data2 or a zero-extended immediate (amount), shifts iteratively, and produces the writeback triple (wr_en, wr_reg, wr_data) that feeds the register file's write, write_reg and write_data ports.
- Also produces the carry flag for the flags unit.

---
 rtl/shift_exec_unit.sv | 151 +++++++++++++++
 tb/tb_shift_exec_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: multi-cycle shift execute stage fed by the register file.
// It takes a value and an unsigned shift amount and shifts by STEP bits per
// cycle. It then issues one register-file writeback (wr_en/wr_reg/wr_data)
// and returns the last bit shifted out as carry.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   start    in   request, sampled only while idle
//   op[1:0]  in   00 sll, 01 srl, 10 sra, 11 pass
//   data_in  in   value to shift
//   shamt    in   shift amount (>= 32 saturates to 32)
//   dest_reg in   destination register index
//   busy     out  high while shifting or completing
//   done     out  one-cycle completion pulse
//   result   out  shifted value, held until the next accepted start
//   carry    out  last bit shifted out, held with result
//   wr_en    out  register-file write strobe (equals done)
//   wr_reg   out  latched destination register
//   wr_data  out  equals result
module shift_exec_unit #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [31:0] shamt,
    input  logic [4:0]  dest_reg,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry,
    output logic        wr_en,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_data;
    logic [5:0]  r_count;
    logic [1:0]  r_op;
    logic        r_sign;
    logic        r_carry;
    logic [4:0]  r_dest;

    logic [5:0]  w_load_count;
    logic [5:0]  w_step;
    logic        w_fill;
    logic [63:0] w_wide;
    logic [31:0] w_shifted;
    logic        w_carry;
    logic [4:0]  w_sll_idx;
    logic [4:0]  w_srl_idx;

    // Any set bit above bit 4 means the amount is 32 or more.
    assign w_load_count = (|shamt[31:5]) ? 6'd32 : {1'b0, shamt[4:0]};
    assign w_step       = (r_count < STEP_W) ? r_count : STEP_W;

    // Only meaningful in SHIFT, where w_step is 1..STEP.
    assign w_sll_idx    = 5'(6'd32 - w_step);
    assign w_srl_idx    = 5'(w_step - 6'd1);

    // Right shifts: prepend 32 fill bits so that one wide shift covers
    // srl and sra alike.
    assign w_fill       = (r_op == 2'b10) ? r_sign : 1'b0;
    assign w_wide       = {{32{w_fill}}, r_data} >> w_step;

    always_comb begin
        w_shifted = r_data;
        w_carry   = r_carry;
        if (r_op == 2'b00) begin
            w_shifted = r_data << w_step;
            w_carry   = r_data[w_sll_idx];
        end else begin
            w_shifted = w_wide[31:0];
            w_carry   = r_data[w_srl_idx];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((w_load_count != 6'd0) && (op != 2'b11))
                        w_next = S_SHIFT;
                    else
                        w_next = S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_count == w_step)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_op    <= '0;
            r_sign  <= 1'b0;
            r_carry <= 1'b0;
            r_dest  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data  <= data_in;
                        r_op    <= op;
                        r_sign  <= data_in[31];
                        r_dest  <= dest_reg;
                        r_count <= w_load_count;
                        r_carry <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_shifted;
                    r_carry <= w_carry;
                    r_count <= r_count - w_step;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign wr_en   = done;
    assign result  = r_data;
    assign wr_data = r_data;
    assign carry   = r_carry;
    assign wr_reg  = r_dest;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench: two instances (STEP=1 and STEP=4) share stimulus.
// The driver pushes expected writebacks. The monitors pop them on each wr_en.
module tb_shift_exec_unit;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic [4:0]  rg;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] data_in = '0;
    logic [31:0] shamt = '0;
    logic [4:0]  dest_reg = '0;

    logic        a_busy, a_done, a_carry, a_wr_en;
    logic [31:0] a_result, a_wr_data;
    logic [4:0]  a_wr_reg;
    logic        b_busy, b_done, b_carry, b_wr_en;
    logic [31:0] b_result, b_wr_data;
    logic [4:0]  b_wr_reg;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    shift_exec_unit #(.STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .dest_reg(dest_reg), .busy(a_busy), .done(a_done),
        .result(a_result), .carry(a_carry), .wr_en(a_wr_en),
        .wr_reg(a_wr_reg), .wr_data(a_wr_data)
    );

    shift_exec_unit #(.STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .dest_reg(dest_reg), .busy(b_busy), .done(b_done),
        .result(b_result), .carry(b_carry), .wr_en(b_wr_en),
        .wr_reg(b_wr_reg), .wr_data(b_wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic int unsigned lat(input logic [1:0] o, input logic [31:0] amt,
                                        input int unsigned step);
        int unsigned n;
        n = (amt >= 32) ? 32 : amt;
        if (o == 2'b11) return 0;
        return (n + step - 1) / step;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [31:0] wd,
                           input logic [31:0] res, input logic c, input logic d,
                           input logic [4:0] rg);
        chk({tag, " wr_data"}, wd, e.data);
        chk({tag, " result"},  res, e.data);
        chk({tag, " carry"},   {31'd0, c}, {31'd0, e.carry});
        chk({tag, " done"},    {31'd0, d}, 32'd1);
        chk({tag, " wr_reg"},  {27'd0, rg}, {27'd0, e.rg});
        chk({tag, " latency_cycle"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (rst && a_wr_en) begin
            if (qa.size() == 0) begin
                n_chk++;
                $display("FAIL step1 unexpected wr_en: got wr_data %h required no write", a_wr_data);
            end else begin
                compare("step1", qa.pop_front(), a_wr_data, a_result, a_carry, a_done, a_wr_reg);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b_wr_en) begin
            if (qb.size() == 0) begin
                n_chk++;
                $display("FAIL step4 unexpected wr_en: got wr_data %h required no write", b_wr_data);
            end else begin
                compare("step4", qb.pop_front(), b_wr_data, b_result, b_carry, b_done, b_wr_reg);
            end
        end
    end

    task automatic wait_idle();
        int unsigned k = 0;
        while ((a_busy || b_busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            n_chk++;
            $display("FAIL wait_idle: got busy after %0d cycles required idle", k);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [31:0] amt,
                         input logic [4:0] rg, input logic [31:0] er, input logic ec,
                         input bit push);
        exp_t e;
        wait_idle();
        op = o; data_in = d; shamt = amt; dest_reg = rg; start = 1'b1;
        if (push) begin
            e.data = er; e.carry = ec; e.rg = rg;
            e.cyc = cyc + 1 + lat(o, amt, 1);
            qa.push_back(e);
            e.cyc = cyc + 1 + lat(o, amt, 4);
            qb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset step1 ctl", {26'd0, a_busy, a_done, a_carry, a_wr_en, 1'b0, a_wr_reg}, 32'd0);
        chk("reset step1 result", a_result, 32'd0);
        chk("reset step4 ctl", {26'd0, b_busy, b_done, b_carry, b_wr_en, 1'b0, b_wr_reg}, 32'd0);
        chk("reset step4 result", b_result, 32'd0);

        issue(2'b00, 32'h0000_0001, 32'd4,   5'd5,  32'h0000_0010, 1'b0, 1);
        issue(2'b10, 32'h8000_0000, 32'd31,  5'd1,  32'hFFFF_FFFF, 1'b0, 1);
        issue(2'b01, 32'h8000_0001, 32'd40,  5'd2,  32'h0000_0000, 1'b1, 1);
        issue(2'b00, 32'hDEAD_BEEF, 32'd0,   5'd3,  32'hDEAD_BEEF, 1'b0, 1);
        issue(2'b11, 32'hDEAD_BEEF, 32'd7,   5'd4,  32'hDEAD_BEEF, 1'b0, 1);
        issue(2'b10, 32'h8000_0000, 32'd100, 5'd6,  32'hFFFF_FFFF, 1'b1, 1);
        issue(2'b00, 32'h8000_0001, 32'd32,  5'd7,  32'h0000_0000, 1'b1, 1);
        issue(2'b01, 32'h1234_5678, 32'd4,   5'd8,  32'h0123_4567, 1'b1, 1);
        issue(2'b10, 32'h8000_0010, 32'd5,   5'd0,  32'hFC00_0000, 1'b1, 1);
        issue(2'b00, 32'hC000_0000, 32'd2,   5'd31, 32'h0000_0000, 1'b1, 1);

        // Start pulsed while busy must be ignored by both instances.
        issue(2'b00, 32'h0000_000F, 32'd8,   5'd12, 32'h0000_0F00, 1'b0, 1);
        repeat (2) @(negedge clk);
        op = 2'b01; data_in = 32'h1234_5678; shamt = 32'd4; dest_reg = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored start step1 queue", qa.size(), 32'd0);
        chk("ignored start step4 queue", qb.size(), 32'd0);

        // Asynchronous reset mid-shift: no writeback may follow.
        issue(2'b01, 32'hFFFF_FFFF, 32'd20,  5'd13, 32'h0, 1'b0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort step1 ctl", {26'd0, a_busy, a_done, a_carry, a_wr_en, 1'b0, a_wr_reg}, 32'd0);
        chk("abort step1 result", a_result, 32'd0);
        chk("abort step4 ctl", {26'd0, b_busy, b_done, b_carry, b_wr_en, 1'b0, b_wr_reg}, 32'd0);
        chk("abort step4 result", b_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        issue(2'b00, 32'h0000_0001, 32'd1,   5'd10, 32'h0000_0002, 1'b0, 1);
        wait_idle();
        repeat (4) @(negedge clk);
        chk("final step1 queue", qa.size(), 32'd0);
        chk("final step4 queue", qb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
